// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with same-cycle write-to-read bypass
// and a per-register busy scoreboard for issue hazard detection.
module regfile_mp_sb #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NREG     = 32,
   parameter int unsigned NRD      = 2,
   parameter int unsigned NWR      = 2,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned ZERO_REG = 1,
   localparam int unsigned AW      = $clog2(NREG)
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic [NRD*AW-1:0]    i_rnum,
   output logic [NRD*XLEN-1:0]  o_rd,
   output logic [NRD-1:0]       o_rbusy,
   input  logic [NWR-1:0]       i_wen,
   input  logic [NWR*AW-1:0]    i_wnum,
   input  logic [NWR*XLEN-1:0]  i_wd,
   input  logic                 i_iss_en,
   input  logic [AW-1:0]        i_iss_num,
   output logic                 o_iss_stall,
   output logic [NREG-1:0]      o_busy_vec
);

   localparam bit P_BYP = (BYPASS != 0);
   localparam bit P_ZR  = (ZERO_REG != 0);

   logic [XLEN-1:0] r_x [NREG];
   logic [NREG-1:0] r_busy;

   logic [NREG-1:0] w_clr;
   logic [NREG-1:0] w_set;
   logic [XLEN-1:0] w_wdat [NREG];
   logic            w_stall;

   function automatic logic f_in_range(input logic [AW-1:0] n);
      return ((AW+1)'(n) < (AW+1)'(NREG));
   endfunction

   // A register number that may actually be written or marked busy
   function automatic logic f_valid(input logic [AW-1:0] n);
      return f_in_range(n) && !(P_ZR && (n == '0));
   endfunction

   // Write decode: later (higher-index) ports override earlier ones
   always_comb begin
      w_clr = '0;
      for (int r = 0; r < NREG; r++) w_wdat[r] = '0;
      for (int p = 0; p < NWR; p++) begin
         if (i_wen[p] && f_valid(i_wnum[p*AW +: AW])) begin
            w_clr[i_wnum[p*AW +: AW]]  = 1'b1;
            w_wdat[i_wnum[p*AW +: AW]] = i_wd[p*XLEN +: XLEN];
         end
      end
   end

   // Issue hazard check and busy set
   always_comb begin
      w_stall = 1'b0;
      w_set   = '0;
      if (i_iss_en && f_in_range(i_iss_num))
         w_stall = r_busy[i_iss_num] && !(P_BYP && w_clr[i_iss_num]);
      if (i_iss_en && !w_stall && f_valid(i_iss_num))
         w_set[i_iss_num] = 1'b1;
   end

   // Read ports with optional bypass of same-cycle writes
   always_comb begin
      o_rd    = '0;
      o_rbusy = '0;
      for (int k = 0; k < NRD; k++) begin
         if (f_in_range(i_rnum[k*AW +: AW])) begin
            o_rd[k*XLEN +: XLEN] = r_x[i_rnum[k*AW +: AW]];
            o_rbusy[k]           = r_busy[i_rnum[k*AW +: AW]];
            if (P_BYP && w_clr[i_rnum[k*AW +: AW]]) begin
               o_rd[k*XLEN +: XLEN] = w_wdat[i_rnum[k*AW +: AW]];
               o_rbusy[k]           = w_set[i_rnum[k*AW +: AW]];
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         for (int r = 0; r < NREG; r++) r_x[r] <= '0;
         r_busy <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            if (w_clr[r]) r_x[r] <= w_wdat[r];
         end
         r_busy <= w_set | (r_busy & ~w_clr);
      end
   end

   assign o_iss_stall = w_stall;
   assign o_busy_vec  = r_busy;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: one bypassing and one non-bypassing
// instance share the same stimulus; expected values are hand-computed.
module tb_regfile_mp_sb;

   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 32;
   localparam int unsigned NRD  = 2;
   localparam int unsigned NWR  = 2;
   localparam int unsigned AW   = 5;

   logic                i_clk = 1'b0;
   logic                i_rstn;
   logic [NRD*AW-1:0]   i_rnum;
   logic [NWR-1:0]      i_wen;
   logic [NWR*AW-1:0]   i_wnum;
   logic [NWR*XLEN-1:0] i_wd;
   logic                i_iss_en;
   logic [AW-1:0]       i_iss_num;

   logic [NRD*XLEN-1:0] d_rd,    n_rd;
   logic [NRD-1:0]      d_rbusy, n_rbusy;
   logic                d_stall, n_stall;
   logic [NREG-1:0]     d_busy,  n_busy;

   int n_cmp = 0;
   int n_err = 0;

   always #5 i_clk = ~i_clk;

   regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_REG(1)) u_dut (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_rnum(i_rnum), .o_rd(d_rd), .o_rbusy(d_rbusy),
      .i_wen(i_wen), .i_wnum(i_wnum), .i_wd(i_wd), .i_iss_en(i_iss_en), .i_iss_num(i_iss_num),
      .o_iss_stall(d_stall), .o_busy_vec(d_busy)
   );

   regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0), .ZERO_REG(1)) u_nb (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_rnum(i_rnum), .o_rd(n_rd), .o_rbusy(n_rbusy),
      .i_wen(i_wen), .i_wnum(i_wnum), .i_wd(i_wd), .i_iss_en(i_iss_en), .i_iss_num(i_iss_num),
      .o_iss_stall(n_stall), .o_busy_vec(n_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_rd(input int k, input logic [AW-1:0] num);
      i_rnum[k*AW +: AW] = num;
   endtask

   task automatic set_wr(input int p, input logic en, input logic [AW-1:0] num, input logic [31:0] data);
      i_wen[p]               = en;
      i_wnum[p*AW +: AW]     = num;
      i_wd[p*XLEN +: XLEN]   = data;
   endtask

   task automatic idle();
      i_wen    = '0;
      i_wnum   = '0;
      i_wd     = '0;
      i_iss_en = 1'b0;
      i_iss_num = '0;
   endtask

   function automatic logic [31:0] drd(input int k);
      return d_rd[k*XLEN +: XLEN];
   endfunction

   function automatic logic [31:0] nrd(input int k);
      return n_rd[k*XLEN +: XLEN];
   endfunction

   initial begin
      i_rstn = 1'b0;
      i_rnum = '0;
      idle();
      repeat (2) cyc();
      i_rstn = 1'b1;

      // Random activity, then two reset cycles with writes still applied
      for (int c = 0; c < 9; c++) begin
         set_wr(0, 1'b1, AW'($urandom_range(1, 31)), $urandom);
         set_wr(1, 1'b1, AW'($urandom_range(1, 31)), $urandom);
         i_iss_en  = 1'($urandom_range(0, 1));
         i_iss_num = AW'($urandom_range(0, 31));
         if (c >= 7) i_rstn = 1'b0;
         cyc();
      end
      idle();
      i_rstn = 1'b1;
      #1;
      for (int r = 0; r < 32; r++) begin
         set_rd(0, AW'(r));
         set_rd(1, AW'(31 - r));
         #1;
         chk("rst_rd0_byp", drd(0), 32'h0);
         chk("rst_rd1_nbyp", nrd(1), 32'h0);
      end
      chk("rst_busy_byp", d_busy, 32'h0);
      chk("rst_busy_nbyp", n_busy, 32'h0);
      chk("rst_rbusy", 32'(d_rbusy), 32'h0);
      chk("rst_stall", 32'(d_stall), 32'h0);

      // Two ports write x5 in one cycle: port 1 wins, also on the bypass path
      set_wr(0, 1'b1, 5'd5, 32'h11);
      set_wr(1, 1'b1, 5'd5, 32'h22);
      set_rd(0, 5'd5);
      #1;
      chk("ww_bypass_rd", drd(0), 32'h22);
      chk("ww_nbyp_rd_old", nrd(0), 32'h0);
      cyc();
      idle();
      #1;
      chk("ww_rd_byp", drd(0), 32'h22);
      chk("ww_rd_nbyp", nrd(0), 32'h22);

      // Preload x7, then write it while reading it
      set_wr(0, 1'b1, 5'd7, 32'h1234);
      cyc();
      idle();
      set_wr(1, 1'b1, 5'd7, 32'hDEAD);
      set_rd(1, 5'd7);
      #1;
      chk("byp_rd_new", drd(1), 32'hDEAD);
      chk("nbyp_rd_old", nrd(1), 32'h1234);
      cyc();
      idle();
      #1;
      chk("nbyp_rd_next", nrd(1), 32'hDEAD);

      // Write and issue x0: dropped, never busy, never stalls
      set_wr(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
      i_iss_en  = 1'b1;
      i_iss_num = 5'd0;
      set_rd(0, 5'd0);
      #1;
      chk("x0_stall", 32'(d_stall), 32'h0);
      chk("x0_rd_same", drd(0), 32'h0);
      cyc();
      idle();
      #1;
      chk("x0_rd", drd(0), 32'h0);
      chk("x0_busy", 32'(d_busy[0]), 32'h0);
      chk("x0_rbusy", 32'(d_rbusy[0]), 32'h0);

      // Scoreboard on x3
      i_iss_en  = 1'b1;
      i_iss_num = 5'd3;
      #1;
      chk("iss3_stall0", 32'(d_stall), 32'h0);
      cyc();
      #1;
      chk("iss3_busy", d_busy, 32'h8);
      chk("iss3_again_stall", 32'(d_stall), 32'h1);
      chk("iss3_again_stall_nb", 32'(n_stall), 32'h1);
      set_rd(1, 5'd3);
      #1;
      chk("iss3_rbusy", 32'(d_rbusy[1]), 32'h1);
      cyc();
      #1;
      chk("iss3_hold_busy", d_busy, 32'h8);
      set_wr(0, 1'b1, 5'd3, 32'h33);
      #1;
      chk("wr_iss3_stall_byp", 32'(d_stall), 32'h0);
      chk("wr_iss3_stall_nb", 32'(n_stall), 32'h1);
      chk("wr_iss3_rbusy_byp", 32'(d_rbusy[1]), 32'h1);
      chk("wr_iss3_rd_byp", drd(1), 32'h33);
      cyc();
      idle();
      #1;
      chk("wr_iss3_busy_byp", d_busy, 32'h8);
      chk("wr_iss3_busy_nb", n_busy, 32'h0);
      chk("wr_iss3_rd_nb", nrd(1), 32'h33);
      set_wr(1, 1'b1, 5'd3, 32'h44);
      #1;
      chk("wr3_rbusy_clr", 32'(d_rbusy[1]), 32'h0);
      cyc();
      idle();
      #1;
      chk("wr3_busy_clr", d_busy, 32'h0);
      chk("wr3_rd", drd(1), 32'h44);

      // Top register through the high write port
      set_wr(1, 1'b1, 5'd31, 32'hA5A5_5A5A);
      cyc();
      idle();
      set_rd(0, 5'd31);
      #1;
      chk("x31_rd", drd(0), 32'hA5A5_5A5A);
      chk("x31_rbusy", 32'(d_rbusy[0]), 32'h0);

      // Issue x9 then reset alongside a write of x9
      i_iss_en  = 1'b1;
      i_iss_num = 5'd9;
      cyc();
      idle();
      #1;
      chk("iss9_busy_byp", d_busy, 32'h200);
      chk("iss9_busy_nb", n_busy, 32'h200);
      i_rstn = 1'b0;
      set_wr(0, 1'b1, 5'd9, 32'h99);
      cyc();
      idle();
      i_rstn = 1'b1;
      set_rd(0, 5'd9);
      set_rd(1, 5'd5);
      #1;
      chk("rst9_busy", d_busy, 32'h0);
      chk("rst9_rd", drd(0), 32'h0);
      chk("rst9_rd_nb", nrd(0), 32'h0);
      chk("rst9_x5", drd(1), 32'h0);
      cyc();
      #1;
      chk("rst9_rd_after", drd(0), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
